tinyrv_mem_sched: RTL and testbench

- Schedules the single byte-wide external memory port of the tinyrv core between two requesters: instruction fetch (read-only, 32-bit) and load/store unit (read/write, 8/16/32-bit).
- Serialises each granted access into address bytes followed by data bytes on the pin-level bus carried by the top-level uio/uo pins.
- Sits between the core pipeline and the top-level pin wrapper.

---
 rtl/tinyrv_mem_pkg.sv | 38 +++
 rtl/tinyrv_mem_sched.sv | 170 +++++++++++++++++
 tb/tb_tinyrv_mem_sched.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinyrv_mem_pkg.sv
// Shared definitions for the tinyrv external memory scheduler.
// Holds the pin-level bus command encodings, LSU access-size encodings,
// the scheduler state enum, requester ids and the size-to-byte-count helper.
package tinyrv_mem_pkg;

    // ext_cmd encodings
    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_ADDR  = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    // lsu_size encodings (2'b11 behaves as a word)
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Requester ids, also used for the round-robin history
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_LSU   = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } state_e;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] nbytes;
        case (size)
            SIZE_BYTE: nbytes = 3'd1;
            SIZE_HALF: nbytes = 3'd2;
            default:   nbytes = 3'd4;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/tinyrv_mem_sched.sv
// tinyrv external memory scheduler.
// Arbitrates the single byte-wide external memory port between instruction
// fetch and the load/store unit (2-way round robin on ties) and serialises
// each granted access as ADDR_BYTES address bytes (MSB first) followed by
// 1/2/4 data bytes (LSB first).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr/if_ack           fetch requester (32-bit reads)
//   lsu_req/we/size/addr/wdata/ack  load/store requester
//   rdata                           assembled read data, zero-extended
//   ext_cmd/ext_dout/ext_oe         pin-level bus outputs
//   ext_din/ext_ready               pin-level bus inputs
//   busy                            scheduler not idle
module tinyrv_mem_sched
    import tinyrv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter bit          FETCH_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_size,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_ack,
    output logic [31:0]       rdata,
    output logic [1:0]        ext_cmd,
    output logic [7:0]        ext_dout,
    output logic              ext_oe,
    input  logic [7:0]        ext_din,
    input  logic              ext_ready,
    output logic              busy
);

    localparam int ADDR_BYTES = ADDR_W / 8;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              id_q, id_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        nlast_q, nlast_d;   // index of the final data byte
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              pick_lsu;
    logic [ADDR_W-1:0] addr_sh;

    // On a tie, grant whichever requester did not win last time
    assign pick_lsu = lsu_req && (!if_req || (last_q == GRANT_FETCH));

    // Current address byte, most significant first
    assign addr_sh = addr_q >> (8 * (ADDR_BYTES - 1 - int'(cnt_q)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        last_d   = last_q;
        addr_d   = addr_q;
        we_d     = we_q;
        nlast_d  = nlast_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ext_cmd  = CMD_IDLE;
        ext_dout = 8'h00;
        ext_oe   = 1'b0;
        if_ack   = 1'b0;
        lsu_ack  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_req || lsu_req) begin
                    state_d = StAddr;
                    cnt_d   = 2'd0;
                    if (pick_lsu) begin
                        id_d    = GRANT_LSU;
                        last_d  = GRANT_LSU;
                        addr_d  = lsu_addr;
                        we_d    = lsu_we;
                        nlast_d = 2'(size_to_nbytes(lsu_size) - 3'd1);
                        wdata_d = lsu_wdata;
                    end else begin
                        id_d    = GRANT_FETCH;
                        last_d  = GRANT_FETCH;
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        nlast_d = 2'd3;
                    end
                end
            end
            StAddr: begin
                ext_cmd  = CMD_ADDR;
                ext_oe   = 1'b1;
                ext_dout = addr_sh[7:0];
                if (ext_ready) begin
                    if (cnt_q == 2'(ADDR_BYTES - 1)) begin
                        state_d = StData;
                        cnt_d   = 2'd0;
                        if (!we_q) begin
                            rdata_d = 32'h0;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StData: begin
                if (we_q) begin
                    ext_cmd  = CMD_WRITE;
                    ext_oe   = 1'b1;
                    ext_dout = wdata_q[{cnt_q, 3'b000} +: 8];
                end else begin
                    ext_cmd = CMD_READ;
                end
                if (ext_ready) begin
                    if (!we_q) begin
                        rdata_d[{cnt_q, 3'b000} +: 8] = ext_din;
                    end
                    if (cnt_q == nlast_q) begin
                        state_d = StDone;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StDone: begin
                if_ack  = (id_q == GRANT_FETCH);
                lsu_ack = (id_q == GRANT_LSU);
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            id_q    <= GRANT_FETCH;
            last_q  <= FETCH_FIRST ? GRANT_LSU : GRANT_FETCH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            nlast_q <= 2'd0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            nlast_q <= nlast_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_tinyrv_mem_sched.sv
// Self-checking bench for tinyrv_mem_sched (ADDR_W=16, FETCH_FIRST=1).
// Table of single transactions with expected bus beats queued on issue and
// popped as the DUT presents them, plus hand-written tie and reset sequences.
module tb_tinyrv_mem_sched;

    localparam int AW = 16;
    localparam logic [1:0] C_IDLE  = 2'b00;
    localparam logic [1:0] C_ADDR  = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_WRITE = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic          lsu_req;
    logic          lsu_we;
    logic [1:0]    lsu_size;
    logic [AW-1:0] lsu_addr;
    logic [31:0]   lsu_wdata;
    logic          lsu_ack;
    logic [31:0]   rdata;
    logic [1:0]    ext_cmd;
    logic [7:0]    ext_dout;
    logic          ext_oe;
    logic [7:0]    ext_din;
    logic          ext_ready;
    logic          busy;

    tinyrv_mem_sched #(
        .ADDR_W      (AW),
        .FETCH_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .lsu_req   (lsu_req),
        .lsu_we    (lsu_we),
        .lsu_size  (lsu_size),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_ack   (lsu_ack),
        .rdata     (rdata),
        .ext_cmd   (ext_cmd),
        .ext_dout  (ext_dout),
        .ext_oe    (ext_oe),
        .ext_din   (ext_din),
        .ext_ready (ext_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] dout;
        logic       oe;
    } beat_t;

    typedef struct {
        logic        is_lsu;
        logic        we;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] din;
        int          wait_byte;
        int          wait_len;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } txn_t;

    beat_t exp_q[$];
    txn_t  vecs[8];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic do_txn(input txn_t t, input string tag);
        int          nb;
        int          popped;
        int          waits;
        int          cyc;
        bit          done;
        beat_t       b;
        beat_t       f;
        logic [31:0] wd;
        logic [31:0] dn;
        wd = t.wdata;
        dn = t.din;
        nb = !t.is_lsu ? 4 : (t.size == 2'b00 ? 1 : (t.size == 2'b01 ? 2 : 4));
        exp_q.delete();
        b.cmd = C_ADDR; b.oe = 1'b1; b.dout = t.addr[15:8]; exp_q.push_back(b);
        b.dout = t.addr[7:0]; exp_q.push_back(b);
        for (int i = 0; i < nb; i++) begin
            b.cmd  = t.we ? C_WRITE : C_READ;
            b.oe   = t.we;
            b.dout = t.we ? wd[8*i +: 8] : 8'h00;
            exp_q.push_back(b);
        end

        @(negedge clk);
        if (t.is_lsu) begin
            lsu_req = 1'b1; lsu_we = t.we; lsu_size = t.size;
            lsu_addr = t.addr; lsu_wdata = t.wdata;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end
        popped = 0;
        waits  = t.wait_len;
        done   = 1'b0;
        cyc    = 0;
        while (!done && cyc <= 40) begin
            ext_ready = 1'b1;
            ext_din   = 8'hEE;
            if (popped >= 2 && popped < 2 + nb) begin
                if (popped - 2 == t.wait_byte && waits > 0) begin
                    ext_ready = 1'b0;
                    waits--;
                end else begin
                    ext_din = dn[8*(popped-2) +: 8];
                end
            end
            #1;
            if (cyc == 0) check({tag, " busy_at_idle"}, {31'b0, busy}, 32'd0);
            if (if_ack || lsu_ack) begin
                check({tag, " if_ack"}, {31'b0, if_ack}, {31'b0, !t.is_lsu});
                check({tag, " lsu_ack"}, {31'b0, lsu_ack}, {31'b0, t.is_lsu});
                check({tag, " latency"}, cyc, t.exp_lat);
                check({tag, " cmd_done"}, {30'b0, ext_cmd}, {30'b0, C_IDLE});
                check({tag, " oe_done"}, {31'b0, ext_oe}, 32'd0);
                check({tag, " beats_left"}, exp_q.size(), 32'd0);
                if (t.chk_rdata) check({tag, " rdata"}, rdata, t.exp_rdata);
                if_req  = 1'b0;
                lsu_req = 1'b0;
                done    = 1'b1;
            end else if (ext_cmd != C_IDLE) begin
                if (exp_q.size() == 0) begin
                    fail_now({tag, " unexpected bus beat"});
                end else begin
                    f = exp_q[0];
                    check({tag, " cmd"}, {30'b0, ext_cmd}, {30'b0, f.cmd});
                    check({tag, " oe"}, {31'b0, ext_oe}, {31'b0, f.oe});
                    check({tag, " busy"}, {31'b0, busy}, 32'd1);
                    if (f.oe) check({tag, " dout"}, {24'b0, ext_dout}, {24'b0, f.dout});
                    if (ext_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            fail_now({tag, " timeout waiting for ack"});
            if_req  = 1'b0;
            lsu_req = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_lsu;
        int   k;
        bit   seen;
        txn_t t;

        vecs[0] = '{is_lsu:1'b0, we:1'b0, size:2'b10, addr:16'h1234, wdata:32'h0,
                    din:32'h12345678, wait_byte:-1, wait_len:0, chk_rdata:1'b1,
                    exp_rdata:32'h12345678, exp_lat:7};
        vecs[1] = '{is_lsu:1'b1, we:1'b1, size:2'b00, addr:16'h00FF, wdata:32'hAABBCCDD,
                    din:32'h0, wait_byte:-1, wait_len:0, chk_rdata:1'b0,
                    exp_rdata:32'h0, exp_lat:4};
        vecs[2] = '{is_lsu:1'b1, we:1'b0, size:2'b01, addr:16'h4000, wdata:32'h0,
                    din:32'hDEAD9234, wait_byte:1, wait_len:3, chk_rdata:1'b1,
                    exp_rdata:32'h00009234, exp_lat:8};
        vecs[3] = '{is_lsu:1'b1, we:1'b1, size:2'b10, addr:16'hBEEF, wdata:32'h01020304,
                    din:32'h0, wait_byte:-1, wait_len:0, chk_rdata:1'b0,
                    exp_rdata:32'h0, exp_lat:7};
        vecs[4] = '{is_lsu:1'b1, we:1'b0, size:2'b00, addr:16'h0001, wdata:32'h0,
                    din:32'hFFFFFFA5, wait_byte:-1, wait_len:0, chk_rdata:1'b1,
                    exp_rdata:32'h000000A5, exp_lat:4};
        vecs[5] = '{is_lsu:1'b1, we:1'b0, size:2'b11, addr:16'h8000, wdata:32'h0,
                    din:32'hCAFEF00D, wait_byte:-1, wait_len:0, chk_rdata:1'b1,
                    exp_rdata:32'hCAFEF00D, exp_lat:7};
        vecs[6] = '{is_lsu:1'b0, we:1'b0, size:2'b10, addr:16'hFFFC, wdata:32'h0,
                    din:32'h89ABCDEF, wait_byte:0, wait_len:2, chk_rdata:1'b1,
                    exp_rdata:32'h89ABCDEF, exp_lat:9};
        vecs[7] = '{is_lsu:1'b1, we:1'b1, size:2'b01, addr:16'h1000, wdata:32'h1111BEEF,
                    din:32'h0, wait_byte:-1, wait_len:0, chk_rdata:1'b0,
                    exp_rdata:32'h0, exp_lat:5};

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
        lsu_size = 2'b00; lsu_addr = '0; lsu_wdata = 32'h0; ext_din = 8'h00; ext_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ext_cmd", {30'b0, ext_cmd}, 32'd0);
        check("reset ext_dout", {24'b0, ext_dout}, 32'd0);
        check("reset ext_oe", {31'b0, ext_oe}, 32'd0);
        check("reset if_ack", {31'b0, if_ack}, 32'd0);
        check("reset lsu_ack", {31'b0, lsu_ack}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        // Tie sequence: both held throughout, grants must go fetch, LSU, fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 16'h0200;
        ext_ready = 1'b1; ext_din = 8'h5A;
        for (int g = 0; g < 3; g++) begin
            exp_lsu = (g == 1);
            seen = 1'b0;
            k = 0;
            while (!seen && k < 20) begin
                @(negedge clk);
                k++;
                if (if_ack || lsu_ack) seen = 1'b1;
            end
            if (!seen) begin
                fail_now("tie timeout");
            end else begin
                check("tie lsu_ack", {31'b0, lsu_ack}, {31'b0, exp_lsu});
                check("tie if_ack", {31'b0, if_ack}, {31'b0, !exp_lsu});
            end
        end
        if_req = 1'b0;
        lsu_req = 1'b0;

        for (int i = 0; i < 8; i++) begin
            t = vecs[i];
            do_txn(t, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a word write's data phase
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'b10; lsu_addr = 16'h2222;
        lsu_wdata = 32'h33445566; ext_ready = 1'b1;
        k = 0;
        while (ext_cmd != C_WRITE && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (ext_cmd != C_WRITE) fail_now("rst_mid never reached WRITE");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid ext_cmd", {30'b0, ext_cmd}, 32'd0);
        check("rst_mid ext_oe", {31'b0, ext_oe}, 32'd0);
        check("rst_mid ext_dout", {24'b0, ext_dout}, 32'd0);
        check("rst_mid busy", {31'b0, busy}, 32'd0);
        check("rst_mid rdata", rdata, 32'd0);
        check("rst_mid lsu_ack", {31'b0, lsu_ack}, 32'd0);
        lsu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_ack || lsu_ack || busy) seen = 1'b1;
        end
        check("rst_mid no ack after reset", {31'b0, seen}, 32'd0);

        t = '{is_lsu:1'b1, we:1'b1, size:2'b10, addr:16'h2222, wdata:32'h33445566,
              din:32'h0, wait_byte:-1, wait_len:0, chk_rdata:1'b0,
              exp_rdata:32'h0, exp_lat:7};
        do_txn(t, "reissue");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
